// File: rtl/ram4k_bist_pkg.sv
// Shared definitions for the RAM4K built-in self-test engine.
//   - default address/data widths of the RAM4K port
//   - FSM state encoding used by ram4k_bist
package ram4k_bist_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram4k_bist_pattern_gen.sv
// Combinational pattern/address generator shared by the write and read
// passes of ram4k_bist.
//   seed : pattern seed             base : first word of the window
//   idx  : word index within window
//   pat  : seed + idx (mod 2^DATA_W)
//   addr : base + idx (mod 2^ADDR_W), so the window wraps past the top
module bist_pattern_gen
  import ram4k_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   idx,
  output logic [DATA_W-1:0] pat,
  output logic [ADDR_W-1:0] addr
);

  assign pat  = seed + DATA_W'(idx);
  assign addr = base + ADDR_W'(idx);

endmodule

// File: rtl/ram4k_bist.sv
// RAM4K self-test / fill engine. On start it writes seed+i over a window of
// words starting at base_addr, reads the window back, and reports the result.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a test (accepted only in IDLE)
//   base_addr, length, seed : test window and pattern, latched on start
//   mem_address, mem_data_in, mem_write_enable : drive the RAM4K port
//   mem_data_out      : asynchronous read data from the RAM
//   busy              : high while writing or reading
//   done              : one-cycle pulse when the test completes
//   pass, err_count, fail_addr : result of the last completed test
module ram4k_bist
  import ram4k_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_next;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;
  logic              err_seen;

  logic [DATA_W-1:0] pat;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              mismatch;
  logic [ADDR_W:0]   err_next;
  logic              we_raw;

  bist_pattern_gen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_pattern_gen (
    .seed (seed_q),
    .base (base_q),
    .idx  (idx),
    .pat  (pat),
    .addr (addr)
  );

  assign last     = (idx == (len_q - IDX_ONE));
  assign mismatch = (state == READ) && (mem_data_out != pat);
  assign err_next = err_count + {{ADDR_W{1'b0}}, mismatch};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (length != '0) ? WRITE : DONE;
      WRITE: if (last)  state_next = READ;
      READ:  if (last)  state_next = DONE;
      DONE:             state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    we_raw      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    unique case (state)
      IDLE: ;
      WRITE: begin
        busy        = 1'b1;
        we_raw      = 1'b1;
        mem_address = addr;
        mem_data_in = pat;
      end
      READ: begin
        busy        = 1'b1;
        mem_address = addr;
      end
      DONE: done = 1'b1;
    endcase
  end

  // Reset gates the write strobe combinationally so an aborting cycle never
  // commits a word.
  assign mem_write_enable = we_raw & ~rst;

  // Index, latched test parameters and result scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      len_q     <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      err_count <= '0;
      fail_addr <= '0;
      err_seen  <= 1'b0;
      pass      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            len_q     <= length;
            seed_q    <= seed;
            err_count <= '0;
            fail_addr <= '0;
            err_seen  <= 1'b0;
            idx       <= '0;
            // A zero-length test goes straight to DONE and trivially passes.
            if (length == '0) pass <= 1'b1;
          end
        end
        WRITE: idx <= last ? '0 : idx + IDX_ONE;
        READ: begin
          err_count <= err_next;
          if (mismatch && !err_seen) begin
            fail_addr <= addr;
            err_seen  <= 1'b1;
          end
          idx <= idx + IDX_ONE;
          // The final compare lands on this same edge, so use err_next.
          if (last) pass <= (err_next == '0);
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram4k_bist.sv
// Self-checking bench for ram4k_bist with an attached RAM4K model
// (synchronous write, asynchronous read, optional bit-3 stuck-at-0 fault).
module tb_ram4k_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic [15:0] seed;
  logic [11:0] mem_address;
  logic [15:0] mem_data_in;
  logic        mem_write_enable;
  logic [15:0] mem_data_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [12:0] err_count;
  logic [11:0] fail_addr;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  logic [15:0] ram [0:4095];
  bit          fault_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write_enable) ram[mem_address] <= mem_data_in;
  assign mem_data_out = fault_en ? (ram[mem_address] & 16'hFFF7) : ram[mem_address];

  ram4k_bist #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .base_addr        (base_addr),
    .length           (length),
    .seed             (seed),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_data_out     (mem_data_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .fail_addr        (fail_addr)
  );

  // Pulse start for one edge, then scramble the inputs to show they are not
  // sampled after the start edge. Returns at the negedge of cycle 1.
  task automatic launch(input logic [11:0] b, input logic [12:0] l, input logic [15:0] s);
    @(negedge clk);
    base_addr = b; length = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = ~b; length = l + 13'd3; seed = ~s;
  endtask

  task automatic push_exp(input logic [11:0] b, input logic [12:0] l, input logic [15:0] s);
    logic [11:0] a;
    logic [15:0] d;
    exp_q.delete();
    for (int i = 0; i < int'(l); i++) begin
      a = b + 12'(i);
      d = s + 16'(i);
      exp_q.push_back('{a, d});
    end
  endtask

  // Collect write transactions until done; cycle 1 is the cycle right after
  // the start edge. Optionally injects a second start at cycle inj_cyc.
  task automatic wait_done(input int budget, input int inj_cyc,
                           input logic [11:0] ib, input logic [12:0] il, input logic [15:0] is,
                           output int cyc, output int rd_cnt, output bit to);
    cyc = 1; rd_cnt = 0; to = 1'b0;
    obs_q.delete();
    forever begin
      if (mem_write_enable) obs_q.push_back('{mem_address, mem_data_in});
      if (busy && !mem_write_enable) rd_cnt++;
      if (done) break;
      if (cyc >= budget) begin to = 1'b1; break; end
      if (cyc == inj_cyc) begin
        start = 1'b1; base_addr = ib; length = il; seed = is;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; seed = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, pass, err_count, fail_addr, mem_address, mem_data_in, mem_write_enable} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%0d fail=%0d addr=%0d din=%h we=%b, required all 0",
               busy, done, pass, err_count, fail_addr, mem_address, mem_data_in, mem_write_enable);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int cyc, rd; bit to; wr_t e, o;
    push_exp(12'd0, 13'd4, 16'd1234);
    launch(12'd0, 13'd4, 16'd1234);
    wait_done(40, 0, '0, '0, '0, cyc, rd, to);
    vectors++;
    if (to || cyc != 9) begin miscompares++; $display("FAIL basic_latency: got %0d (timeout=%0b), required 9", cyc, to); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_wr_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.a !== e.a || o.d !== e.d) begin miscompares++; $display("FAIL basic_write: got %0d/%h, required %0d/%h", o.a, o.d, e.a, e.d); end
    end
    vectors++;
    if (rd != 4) begin miscompares++; $display("FAIL basic_rd_count: got %0d, required 4", rd); end
    vectors++;
    if (pass !== 1'b1 || err_count !== 13'd0 || fail_addr !== 12'd0) begin
      miscompares++; $display("FAIL basic_result: pass=%b err=%0d fail=%0d, required 1/0/0", pass, err_count, fail_addr);
    end
  endtask

  task automatic test_wrap;
    int cyc, rd; bit to; wr_t e, o;
    exp_q.delete();
    exp_q.push_back('{12'd4094, 16'hFFFE});
    exp_q.push_back('{12'd4095, 16'hFFFF});
    exp_q.push_back('{12'd0,    16'h0000});
    exp_q.push_back('{12'd1,    16'h0001});
    launch(12'd4094, 13'd4, 16'hFFFE);
    wait_done(40, 0, '0, '0, '0, cyc, rd, to);
    vectors++;
    if (to || obs_q.size() != 4) begin miscompares++; $display("FAIL wrap_wr_count: got %0d (timeout=%0b), required 4", obs_q.size(), to); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.a !== e.a || o.d !== e.d) begin miscompares++; $display("FAIL wrap_write: got %0d/%h, required %0d/%h", o.a, o.d, e.a, e.d); end
    end
    vectors++;
    if (pass !== 1'b1 || err_count !== 13'd0) begin miscompares++; $display("FAIL wrap_result: pass=%b err=%0d, required 1/0", pass, err_count); end
  endtask

  task automatic test_fault;
    int cyc, rd; bit to;
    fault_en = 1'b1;
    launch(12'd100, 13'd16, 16'd0);
    wait_done(80, 0, '0, '0, '0, cyc, rd, to);
    vectors++;
    if (to || cyc != 33) begin miscompares++; $display("FAIL fault_latency: got %0d (timeout=%0b), required 33", cyc, to); end
    vectors++;
    if (pass !== 1'b0 || err_count !== 13'd8 || fail_addr !== 12'd108) begin
      miscompares++; $display("FAIL fault_result: pass=%b err=%0d fail=%0d, required 0/8/108", pass, err_count, fail_addr);
    end
    fault_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (pass !== 1'b0 || err_count !== 13'd8 || fail_addr !== 12'd108 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL fault_hold: pass=%b err=%0d fail=%0d done=%b busy=%b, required 0/8/108/0/0",
                              pass, err_count, fail_addr, done, busy);
    end
  endtask

  task automatic test_zero_length;
    int cyc, rd; bit to;
    launch(12'd7, 13'd0, 16'd9);
    wait_done(10, 0, '0, '0, '0, cyc, rd, to);
    vectors++;
    if (to || cyc != 1) begin miscompares++; $display("FAIL zero_latency: got %0d (timeout=%0b), required 1", cyc, to); end
    vectors++;
    if (obs_q.size() != 0 || rd != 0) begin miscompares++; $display("FAIL zero_activity: writes=%0d reads=%0d, required 0/0", obs_q.size(), rd); end
    vectors++;
    if (pass !== 1'b1 || err_count !== 13'd0 || fail_addr !== 12'd0) begin
      miscompares++; $display("FAIL zero_result: pass=%b err=%0d fail=%0d, required 1/0/0", pass, err_count, fail_addr);
    end
  endtask

  task automatic test_start_busy;
    int cyc, rd; bit to; wr_t e, o;
    push_exp(12'd300, 13'd8, 16'h1111);
    launch(12'd300, 13'd8, 16'h1111);
    wait_done(60, 3, 12'd50, 13'd2, 16'h2222, cyc, rd, to);
    vectors++;
    if (to || cyc != 17) begin miscompares++; $display("FAIL busy_latency: got %0d (timeout=%0b), required 17", cyc, to); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL busy_wr_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.a !== e.a || o.d !== e.d) begin miscompares++; $display("FAIL busy_write: got %0d/%h, required %0d/%h", o.a, o.d, e.a, e.d); end
    end
    vectors++;
    if (pass !== 1'b1 || err_count !== 13'd0) begin miscompares++; $display("FAIL busy_result: pass=%b err=%0d, required 1/0", pass, err_count); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_no_queue: busy=%b after done, required 0", busy); end
  endtask

  task automatic test_reset_mid;
    int cyc, rd; bit to; wr_t e, o;
    // Reset during WRITE: the write strobe must drop in the reset cycle.
    for (int i = 200; i < 204; i++) ram[i] = 16'hDEAD;
    launch(12'd200, 13'd4, 16'h5000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rst_gate_write: we=%b, required 0", mem_write_enable); end
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (ram[200] !== 16'h5000 || ram[201] !== 16'hDEAD) begin
      miscompares++; $display("FAIL rst_ram_contents: ram200=%h ram201=%h, required 5000/dead", ram[200], ram[201]);
    end
    // Reset during READ.
    launch(12'd400, 13'd4, 16'h7777);
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rst_in_read: busy=%b we=%b, required 1/0", busy, mem_write_enable); end
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rst_read_we: we=%b, required 0", mem_write_enable); end
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy, done, pass, err_count, fail_addr, mem_address, mem_data_in, mem_write_enable} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b pass=%b err=%0d fail=%0d addr=%0d din=%h we=%b, required all 0",
               busy, done, pass, err_count, fail_addr, mem_address, mem_data_in, mem_write_enable);
    end
    // A fresh start after reset runs normally.
    push_exp(12'd1000, 13'd3, 16'hABCD);
    launch(12'd1000, 13'd3, 16'hABCD);
    wait_done(40, 0, '0, '0, '0, cyc, rd, to);
    vectors++;
    if (to || cyc != 7) begin miscompares++; $display("FAIL rerun_latency: got %0d (timeout=%0b), required 7", cyc, to); end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rerun_wr_count: got %0d, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.a !== e.a || o.d !== e.d) begin miscompares++; $display("FAIL rerun_write: got %0d/%h, required %0d/%h", o.a, o.d, e.a, e.d); end
    end
    vectors++;
    if (pass !== 1'b1 || err_count !== 13'd0 || fail_addr !== 12'd0) begin
      miscompares++; $display("FAIL rerun_result: pass=%b err=%0d fail=%0d, required 1/0/0", pass, err_count, fail_addr);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_fault;
    test_zero_length;
    test_start_busy;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
